// File: rtl/deflate_pkg.sv
// rtl/deflate_pkg.sv - shared deflate constants, fixed-Huffman tables and packer sizing
package deflate_pkg;

  // Symbol alphabet and field-length limits from RFC 1951
  localparam int MAX_CODE_LEN  = 15;
  localparam int MAX_EXTRA_LEN = 13;
  localparam int LITLEN_SYMS   = 286;
  localparam int DIST_SYMS     = 30;

  // Field and address sizing shared by the packer and the writer
  localparam int FIELD_LEN_W   = 5;
  localparam int PACK_MAX_LEN  = 16;
  localparam int PACK_ACC_W    = 24;
  localparam int BS_ADDR_W     = 16;

  // Block type field of a deflate block header
  typedef enum logic [1:0] {
    BTYPE_STORED   = 2'b00,
    BTYPE_FIXED    = 2'b01,
    BTYPE_DYNAMIC  = 2'b10,
    BTYPE_RESERVED = 2'b11
  } btype_e;

  // Fixed-Huffman literal/length code ranges: base code and code length
  localparam logic [8:0] FIX_LIT_0_BASE   = 9'h030;  // symbols 0..143, 8 bits
  localparam logic [8:0] FIX_LIT_144_BASE = 9'h190;  // symbols 144..255, 9 bits
  localparam logic [8:0] FIX_LIT_256_BASE = 9'h000;  // symbols 256..279, 7 bits
  localparam logic [8:0] FIX_LIT_280_BASE = 9'h0C0;  // symbols 280..287, 8 bits
  localparam logic [FIELD_LEN_W-1:0] FIX_DIST_LEN = 5'd5;
  localparam logic [8:0] EOB_SYM = 9'd256;

  // A Huffman code as handed to the packer: MSB-first code value and its length
  typedef struct packed {
    logic [MAX_CODE_LEN-1:0] code;
    logic [FIELD_LEN_W-1:0]  len;
  } huff_code_t;

  // Fixed literal/length code for a symbol, MSB-first (packer reverses it)
  function automatic huff_code_t fixed_litlen_code(input logic [8:0] sym);
    huff_code_t hc;
    logic [8:0] c;
    hc = '0;
    if (sym < 9'd144) begin
      c      = FIX_LIT_0_BASE + sym;
      hc.len = 5'd8;
    end else if (sym < 9'd256) begin
      c      = FIX_LIT_144_BASE + (sym - 9'd144);
      hc.len = 5'd9;
    end else if (sym < 9'd280) begin
      c      = FIX_LIT_256_BASE + (sym - 9'd256);
      hc.len = 5'd7;
    end else begin
      c      = FIX_LIT_280_BASE + (sym - 9'd280);
      hc.len = 5'd8;
    end
    hc.code = {{(MAX_CODE_LEN-9){1'b0}}, c};
    return hc;
  endfunction

  // Fixed distance code: the 5-bit symbol itself
  function automatic huff_code_t fixed_dist_code(input logic [4:0] sym);
    huff_code_t hc;
    hc      = '0;
    hc.code = {{(MAX_CODE_LEN-5){1'b0}}, sym};
    hc.len  = FIX_DIST_LEN;
    return hc;
  endfunction

endpackage

// File: rtl/bit_reverser.sv
// rtl/bit_reverser.sv - masks a vector to its low len bits and optionally reverses them
module bit_reverser #(
  parameter int W     = 16,
  parameter int LEN_W = 5
) (
  input  logic [W-1:0]     din,
  input  logic [LEN_W-1:0] len,
  input  logic             rev_en,
  output logic [W-1:0]     dout
);

  logic [W-1:0]   masked;
  logic [W-1:0]   rev_full;
  logic [LEN_W:0] shamt;

  // Mask to len bits; reversal mirrors the whole word, then slides the field back to bit 0
  always_comb begin
    masked = din & ~({W{1'b1}} << len);
    for (int i = 0; i < W; i++) begin
      rev_full[i] = masked[W-1-i];
    end
    shamt = (LEN_W+1)'(W) - {1'b0, len};
    dout  = rev_en ? (rev_full >> shamt) : masked;
  end

endmodule

// File: rtl/deflate_bit_packer.sv
// rtl/deflate_bit_packer.sv - packs variable-length deflate fields LSB-first into addressed bytes
import deflate_pkg::*;

module deflate_bit_packer #(
  parameter int MAX_LEN = PACK_MAX_LEN,
  parameter int ADDR_W  = BS_ADDR_W,
  parameter int ACC_W   = PACK_ACC_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MAX_LEN-1:0]     in_bits,
  input  logic [FIELD_LEN_W-1:0] in_len,
  input  logic                   in_reverse,
  input  logic                   in_flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_byte,
  output logic [ADDR_W-1:0]      out_addr,
  output logic                   out_last,
  output logic                   flush_done,
  output logic [31:0]            total_bits,
  output logic                   err_len,
  output logic                   err_wrap
);

  localparam logic [FIELD_LEN_W-1:0] MAX_LEN_L = FIELD_LEN_W'(MAX_LEN);
  localparam logic [4:0]             BYTE_L    = 5'd8;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [4:0]        fill_q, fill_d;
  logic              flush_pending_q, flush_pending_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [31:0]       total_bits_q, total_bits_d;
  logic              err_len_q, err_len_d;
  logic              err_wrap_q, err_wrap_d;
  logic              flush_done_q, flush_done_d;
  logic              ready_en_q, ready_en_d;

  logic [FIELD_LEN_W-1:0] len_clamp;
  logic [MAX_LEN-1:0]     field;
  logic [ACC_W-1:0]       field_shift;
  logic                   accept;
  logic                   drain;

  // Oversized lengths are clamped to the widest field we can place
  assign len_clamp = (in_len > MAX_LEN_L) ? MAX_LEN_L : in_len;

  bit_reverser #(
    .W     (MAX_LEN),
    .LEN_W (FIELD_LEN_W)
  ) u_rev (
    .din    (in_bits),
    .len    (len_clamp),
    .rev_en (in_reverse),
    .dout   (field)
  );

  assign field_shift = ACC_W'(field) << fill_q;

  // Output view straight from state; the byte stays put until the writer takes it
  assign in_ready   = ready_en_q && !flush_pending_q && (fill_q < BYTE_L);
  assign out_valid  = (fill_q >= BYTE_L) || (flush_pending_q && (fill_q != 5'd0));
  assign out_byte   = acc_q[7:0];
  assign out_addr   = out_addr_q;
  assign out_last   = flush_pending_q && (fill_q != 5'd0) && (fill_q <= BYTE_L);
  assign flush_done = flush_done_q;
  assign total_bits = total_bits_q;
  assign err_len    = err_len_q;
  assign err_wrap   = err_wrap_q;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // Next state: append an accepted field, drain a taken byte, or close an empty flush
  always_comb begin
    acc_d           = acc_q;
    fill_d          = fill_q;
    flush_pending_d = flush_pending_q;
    out_addr_d      = out_addr_q;
    total_bits_d    = total_bits_q;
    err_len_d       = err_len_q;
    err_wrap_d      = err_wrap_q;
    flush_done_d    = 1'b0;
    ready_en_d      = 1'b1;

    if (accept) begin
      acc_d           = acc_q | field_shift;
      fill_d          = fill_q + len_clamp;
      total_bits_d    = total_bits_q + 32'(len_clamp);
      flush_pending_d = in_flush;
      if (in_len > MAX_LEN_L) begin
        err_len_d = 1'b1;
      end
    end else if (drain) begin
      if (fill_q >= BYTE_L) begin
        acc_d  = acc_q >> 8;
        fill_d = fill_q - BYTE_L;
      end else begin
        // Padded tail byte: the bits above fill are already zero
        acc_d  = '0;
        fill_d = 5'd0;
      end
      out_addr_d = out_addr_q + ADDR_W'(1);
      if (&out_addr_q) begin
        err_wrap_d = 1'b1;
      end
      if (flush_pending_q && (fill_q <= BYTE_L)) begin
        flush_pending_d = 1'b0;
        flush_done_d    = 1'b1;
      end
    end else if (flush_pending_q && (fill_q == 5'd0)) begin
      flush_pending_d = 1'b0;
      flush_done_d    = 1'b1;
    end
  end

  // State registers with asynchronous reset that drops any held bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q           <= '0;
      fill_q          <= '0;
      flush_pending_q <= 1'b0;
      out_addr_q      <= '0;
      total_bits_q    <= '0;
      err_len_q       <= 1'b0;
      err_wrap_q      <= 1'b0;
      flush_done_q    <= 1'b0;
      ready_en_q      <= 1'b0;
    end else begin
      acc_q           <= acc_d;
      fill_q          <= fill_d;
      flush_pending_q <= flush_pending_d;
      out_addr_q      <= out_addr_d;
      total_bits_q    <= total_bits_d;
      err_len_q       <= err_len_d;
      err_wrap_q      <= err_wrap_d;
      flush_done_q    <= flush_done_d;
      ready_en_q      <= ready_en_d;
    end
  end

endmodule

// File: tb/tb_deflate_bit_packer.sv
// tb/tb_deflate_bit_packer.sv - randomized bit-queue model bench for deflate_bit_packer
module tb_deflate_bit_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_reverse, in_flush;
  logic [15:0] in_bits;
  logic [4:0]  in_len;
  logic        out_valid, out_ready, out_last, flush_done, err_len, err_wrap;
  logic [7:0]  out_byte;
  logic [15:0] out_addr;
  logic [31:0] total_bits;

  always #5 clk = ~clk;

  deflate_bit_packer #(.MAX_LEN(16), .ADDR_W(16), .ACC_W(24)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bits    (in_bits),
    .in_len     (in_len),
    .in_reverse (in_reverse),
    .in_flush   (in_flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_byte   (out_byte),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .flush_done (flush_done),
    .total_bits (total_bits),
    .err_len    (err_len),
    .err_wrap   (err_wrap)
  );

  int vectors = 0;
  int miscompares = 0;
  int dut_done_cnt = 0;

  // Model: the stream is a queue of bits not yet emitted as bytes
  bit          mq[$];
  bit          m_flush, m_done, m_live, m_err_len, m_wrap;
  int unsigned m_addr, m_total;

  typedef struct {
    logic [7:0]  b;
    int unsigned a;
    bit          l;
  } obyte_t;
  obyte_t log_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_flush = 0; m_done = 0; m_live = 0; m_err_len = 0; m_wrap = 0;
    m_addr = 0; m_total = 0;
  endtask

  function automatic bit m_in_ready();
    return m_live && !m_flush && (mq.size() < 8);
  endfunction

  function automatic bit m_out_valid();
    return (mq.size() >= 8) || (m_flush && mq.size() > 0);
  endfunction

  function automatic bit m_last();
    return m_flush && (mq.size() > 0) && (mq.size() <= 8);
  endfunction

  function automatic logic [7:0] m_byte();
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) if (i < mq.size()) b[i] = mq[i];
    return b;
  endfunction

  task automatic check_outputs();
    chk("in_ready", in_ready, m_in_ready());
    chk("out_valid", out_valid, m_out_valid());
    if (m_out_valid()) chk("out_byte", out_byte, m_byte());
    chk("out_last", out_last, m_last());
    chk("out_addr", out_addr, m_addr[15:0]);
    chk("total_bits", total_bits, m_total);
    chk("flush_done", flush_done, m_done);
    chk("err_len", err_len, m_err_len);
    chk("err_wrap", err_wrap, m_wrap);
    if (flush_done === 1'b1) dut_done_cnt++;
  endtask

  // One clock: compare at negedge, drive, then advance the model across the posedge
  task automatic step(input bit v, input logic [15:0] b, input logic [4:0] l,
                      input bit r, input bit f, input bit ordy);
    bit a_hs, o_hs;
    int n;
    @(negedge clk);
    check_outputs();
    in_valid = v; in_bits = b; in_len = l; in_reverse = r; in_flush = f; out_ready = ordy;
    a_hs = v && m_in_ready();
    o_hs = m_out_valid() && ordy;
    if (out_valid === 1'b1 && ordy) log_q.push_back('{out_byte, int'(out_addr), out_last});
    @(posedge clk);
    m_done = 0;
    if (o_hs) begin
      n = (mq.size() >= 8) ? 8 : mq.size();
      repeat (n) void'(mq.pop_front());
      if (m_addr == 65535) m_wrap = 1;
      m_addr = (m_addr + 1) % 65536;
      if (m_flush && mq.size() == 0) begin m_flush = 0; m_done = 1; end
    end else if (m_flush && mq.size() == 0) begin
      m_flush = 0; m_done = 1;
    end
    if (a_hs) begin
      n = (l > 5'd16) ? 16 : int'(l);
      if (l > 5'd16) m_err_len = 1;
      for (int i = 0; i < n; i++) mq.push_back(r ? b[n-1-i] : b[i]);
      m_total += n;
      if (f) m_flush = 1;
    end
    m_live = 1;
  endtask

  task automatic send(input logic [15:0] b, input logic [4:0] l, input bit r, input bit f);
    int tries = 0;
    while (!m_in_ready() && tries < 64) begin
      step(0, 16'h0, 5'd0, 0, 0, 1);
      tries++;
    end
    if (!m_in_ready()) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: actual busy required ready within 64 cycles");
    end
    step(1, b, l, r, f, 1);
  endtask

  task automatic drain(input int n);
    repeat (n) step(0, 16'h0, 5'd0, 0, 0, 1);
  endtask

  logic [7:0] a_bytes [3];
  bit         a_lasts [3];
  int         n0, d0;

  initial begin
    a_bytes = '{8'h4B, 8'h04, 8'h00};
    a_lasts = '{1'b0, 1'b0, 1'b1};
    reset = 1; in_valid = 0; in_bits = 0; in_len = 0; in_reverse = 0; in_flush = 0; out_ready = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_total", total_bits, 0);
    @(posedge clk); #1 reset = 0;

    // Fixed block holding "a": BFINAL, BTYPE, reversed 0x91, reversed EOB + flush
    log_q.delete(); d0 = dut_done_cnt;
    send(16'h1, 5'd1, 0, 0);
    send(16'h1, 5'd2, 0, 0);
    send(16'h91, 5'd8, 1, 0);
    send(16'h00, 5'd7, 1, 1);
    drain(6);
    chk("a_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("a_byte", log_q[i].b, a_bytes[i]);
        chk("a_addr", log_q[i].a, i);
        chk("a_last", log_q[i].l, a_lasts[i]);
      end
    end
    chk("a_flush_done", dut_done_cnt - d0, 1);
    chk("a_total", total_bits, 18);

    // Backpressure on a pending 0x4B
    send(16'h4B, 5'd8, 0, 0);
    n0 = log_q.size();
    repeat (5) begin
      step(0, 16'h0, 5'd0, 0, 0, 0);
      #1;
      chk("bp_byte", out_byte, 8'h4B);
      chk("bp_addr", out_addr, 3);
      chk("bp_in_ready", in_ready, 0);
    end
    drain(3);
    chk("bp_once", log_q.size() - n0, 1);
    chk("bp_logged", log_q[log_q.size()-1].b, 8'h4B);

    // Aligned 16-bit field
    send(16'hABCD, 5'd16, 0, 0);
    drain(3);
    chk("al_lo", log_q[log_q.size()-2].b, 8'hCD);
    chk("al_hi", log_q[log_q.size()-1].b, 8'hAB);
    #1 chk("al_ready", in_ready, 1);

    // Empty flush at fill 0
    n0 = log_q.size();
    send(16'h0, 5'd0, 0, 1);
    #1 chk("ef_done_early", flush_done, 0);
    step(0, 16'h0, 5'd0, 0, 0, 1);
    #1 chk("ef_done", flush_done, 1);
    step(0, 16'h0, 5'd0, 0, 0, 1);
    #1 chk("ef_done_once", flush_done, 0);
    chk("ef_no_bytes", log_q.size() - n0, 0);

    // Oversized length
    send(16'hFFFF, 5'd20, 0, 0);
    drain(3);
    chk("le_b0", log_q[log_q.size()-2].b, 8'hFF);
    chk("le_b1", log_q[log_q.size()-1].b, 8'hFF);
    #1 chk("le_err", err_len, 1);
    chk("le_total", total_bits, 58);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step(($urandom % 4) != 0, 16'($urandom), 5'($urandom_range(0, 20)),
           1'($urandom % 2), ($urandom % 16) == 0, ($urandom % 4) != 0);
    end

    // Reset mid-stream with a byte pending and 5 bits held
    drain(40);
    send(16'h0, 5'd0, 0, 1);
    drain(4);
    send(16'h1ABC, 5'd13, 0, 0);
    #2 reset = 1;
    #1;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_out_addr", out_addr, 0);
    chk("mr_total", total_bits, 0);
    chk("mr_in_ready", in_ready, 0);
    m_reset();
    @(posedge clk); #1 reset = 0;
    log_q.delete();
    send(16'h5A, 5'd8, 0, 0);
    drain(2);
    chk("mr_count", log_q.size(), 1);
    if (log_q.size() == 1) begin
      chk("mr_byte", log_q[0].b, 8'h5A);
      chk("mr_addr", log_q[0].a, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
